// File: rtl/bp_common_pkg.sv
// Shared clint definitions: register offsets, device base and request sizes.
// Imported by the clint top and its timebase.
package bp_common_pkg;

  localparam logic [15:0] msip_offset_gp     = 16'h0000;
  localparam logic [15:0] mtimecmp_offset_gp = 16'h4000;
  localparam logic [15:0] mtime_offset_gp    = 16'hBFF8;

  localparam logic [31:0] clint_dev_base_addr_gp = 32'h0030_0000;

  typedef enum logic [1:0] {
    e_size_1b = 2'd0,
    e_size_2b = 2'd1,
    e_size_4b = 2'd2,
    e_size_8b = 2'd3
  } bp_clint_size_e;

  typedef enum logic {
    e_idle = 1'b0,
    e_resp = 1'b1
  } bp_clint_state_e;

endpackage

// File: rtl/bp_clint_timebase.sv
// Prescaled 64b mtime counter with a masked write-override port.
// A write in the same cycle as a tick wins; the prescaler keeps running.
module bp_clint_timebase
  import bp_common_pkg::*;
#(
  parameter int timebase_div_p = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [63:0] wr_mask,
  input  logic [63:0] wr_data,
  output logic [63:0] mtime
);

  localparam int cnt_w =
    (timebase_div_p > 1) ? $clog2(timebase_div_p) : 1;
  localparam logic [cnt_w-1:0] cnt_max =
    cnt_w'(timebase_div_p - 1);

  logic [cnt_w-1:0] cnt_r;
  logic [63:0]      mtime_r;
  logic             tick;

  assign tick  = (cnt_r == cnt_max);
  assign mtime = mtime_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= '0;
      mtime_r <= '0;
    end else begin
      cnt_r <= tick ? '0 : cnt_r + 1'b1;
      if (wr_en)
        mtime_r <= (mtime_r & ~wr_mask)
                 | (wr_data & wr_mask);
      else if (tick)
        mtime_r <= mtime_r + 64'd1;
    end
  end

endmodule

// File: rtl/bp_clint_mc.sv
// Multi-hart clint: decode, msip/mtimecmp arrays, registered timer irqs
// and a one-outstanding request/response FSM.
module bp_clint_mc
  import bp_common_pkg::*;
#(
  parameter int          num_harts_p    = 4,
  parameter int          paddr_width_p  = 40,
  parameter int          dword_width_p  = 64,
  parameter int          timebase_div_p = 8,
  parameter logic [31:0] base_addr_p    = clint_dev_base_addr_gp
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_w_i,
  input  logic [paddr_width_p-1:0] req_addr_i,
  input  logic [1:0]               req_size_i,
  input  logic [dword_width_p-1:0] req_data_i,
  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic [dword_width_p-1:0] resp_data_o,
  output logic                     resp_err_o,
  output logic [num_harts_p-1:0]   timer_irq_o,
  output logic [num_harts_p-1:0]   software_irq_o
);

  localparam int hw = (num_harts_p > 1) ? $clog2(num_harts_p) : 1;
  localparam logic [paddr_width_p-1:0] base_full =
    paddr_width_p'(base_addr_p);
  localparam logic [31:0] nh = 32'(num_harts_p);

  bp_clint_state_e state_r;

  logic [num_harts_p-1:0] msip_r;
  logic [63:0]            mtimecmp_r [num_harts_p];
  logic [num_harts_p-1:0] timer_irq_r;
  logic [63:0]            mtime;

  logic [63:0] resp_data_r;
  logic        resp_err_r;

  logic [15:0]    off;
  logic           in_win;
  bp_clint_size_e sz;
  logic           sz4;
  logic           sz8;
  logic [11:0]    msip_idx;
  logic [10:0]    cmp_idx;
  logic           sel_msip;
  logic           sel_cmp;
  logic           sel_mtime;
  logic           acc_err;
  logic [hw-1:0]  hart;
  logic [63:0]    wr_mask;
  logic [63:0]    wr_data;
  logic [63:0]    rd_full;
  logic [63:0]    rd_data;
  logic           hs;
  logic           wr_ok;

  assign off      = req_addr_i[15:0];
  assign in_win   = req_addr_i[paddr_width_p-1:16]
                 == base_full[paddr_width_p-1:16];
  assign sz       = bp_clint_size_e'(req_size_i);
  assign sz4      = (sz == e_size_4b) && (req_addr_i[1:0] == 2'b00);
  assign sz8      = (sz == e_size_8b) && (req_addr_i[2:0] == 3'b000);
  assign msip_idx = off[13:2];
  assign cmp_idx  = off[13:3];

  assign sel_msip = in_win
    && (off[15:14] == msip_offset_gp[15:14])
    && ({20'd0, msip_idx} < nh) && sz4;
  assign sel_cmp = in_win
    && (off[15:14] == mtimecmp_offset_gp[15:14])
    && ({21'd0, cmp_idx} < nh) && (sz4 || sz8);
  assign sel_mtime = in_win
    && (off[15:3] == mtime_offset_gp[15:3])
    && (sz4 || sz8);
  assign acc_err = !(sel_msip || sel_cmp || sel_mtime);

  assign hart = sel_msip ? msip_idx[hw-1:0] : cmp_idx[hw-1:0];

  // 4B writes replicate into both halves; the mask picks addr[2]'s half
  always_comb begin
    wr_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    wr_data = req_data_i;
    if (!sz8) begin
      wr_data = {2{req_data_i[31:0]}};
      wr_mask = req_addr_i[2] ? {32'hFFFF_FFFF, 32'h0}
                              : {32'h0, 32'hFFFF_FFFF};
    end
  end

  always_comb begin
    rd_full = '0;
    unique case (1'b1)
      sel_cmp:   rd_full = mtimecmp_r[hart];
      sel_mtime: rd_full = mtime;
      default:   rd_full = '0;
    endcase
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      sel_msip: rd_data = {63'd0, msip_r[hart]};
      sz8:      rd_data = rd_full;
      default:  rd_data = req_addr_i[2] ? {32'd0, rd_full[63:32]}
                                        : {32'd0, rd_full[31:0]};
    endcase
  end

  assign hs    = req_v_i && req_ready_o;
  assign wr_ok = hs && req_w_i && !acc_err;

  bp_clint_timebase #(
    .timebase_div_p (timebase_div_p)
  ) u_timebase (
    .clk     (clk_i),
    .reset   (reset_i),
    .wr_en   (wr_ok && sel_mtime),
    .wr_mask (wr_mask),
    .wr_data (wr_data),
    .mtime   (mtime)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      msip_r      <= '0;
      timer_irq_r <= '0;
      for (int h = 0; h < num_harts_p; h++)
        mtimecmp_r[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      if (wr_ok && sel_msip)
        msip_r[hart] <= req_data_i[0];
      if (wr_ok && sel_cmp)
        mtimecmp_r[hart] <= (mtimecmp_r[hart] & ~wr_mask)
                          | (wr_data & wr_mask);
      for (int h = 0; h < num_harts_p; h++)
        timer_irq_r[h] <= (mtime >= mtimecmp_r[h]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= e_idle;
      resp_data_r <= '0;
      resp_err_r  <= 1'b0;
    end else begin
      unique case (state_r)
        e_idle: if (hs) begin
          state_r     <= e_resp;
          resp_data_r <= req_w_i ? 64'd0 : rd_data;
          resp_err_r  <= acc_err;
        end
        e_resp: if (resp_yumi_i)
          state_r <= e_idle;
        default: state_r <= e_idle;
      endcase
    end
  end

  assign req_ready_o    = (state_r == e_idle);
  assign resp_v_o       = (state_r == e_resp);
  assign resp_data_o    = dword_width_p'(resp_data_r);
  assign resp_err_o     = resp_err_r;
  assign timer_irq_o    = timer_irq_r;
  assign software_irq_o = msip_r;

endmodule
